// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM state, owner encoding and default widths for the
// picorv32 memory bus arbiter.
package mem_bus_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0 = 2'b01;
  localparam logic [1:0] OWN_M1 = 2'b10;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: saturating busy-cycle counter; expired_o flags the
// TIMEOUT-th counted cycle (never asserts when TIMEOUT is 0).
module mem_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (en_i && cnt_q != CW'(TIMEOUT)) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // the count is cleared on grant, so it holds k-1 during the k-th busy cycle
  assign expired_o = (TIMEOUT != 0) && (cnt_q >= CW'(LIM));
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master/one-slave picorv32 bus arbiter with hung-slave
// timeout. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties, else m0 priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);
  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d, pick;
  logic last_q, last_d;
  logic sel0, sel1, own_valid, own_ready, expired, tmo;
  logic [DATA_W-1:0] own_rdata;

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .resetn(resetn),
    .clear_i(state_q == ARB_IDLE),
    .en_i(state_q == ARB_BUSY),
    .expired_o(expired)
  );

  // owner is OWN_NONE whenever idle, so every mux below yields zero there
  assign sel0 = owner_q == OWN_M0;
  assign sel1 = owner_q == OWN_M1;
  assign own_valid = (sel0 & m0_valid) | (sel1 & m1_valid);
  assign tmo = own_valid & expired & ~s_ready;
  assign own_ready = own_valid & (s_ready | expired);
  assign own_rdata = (own_valid & s_ready) ? s_rdata : '0;

  assign s_valid = own_valid & ~tmo;
  assign s_instr = (sel0 & m0_instr) | (sel1 & m1_instr);
  assign s_addr = sel0 ? m0_addr : sel1 ? m1_addr : '0;
  assign s_wdata = sel0 ? m0_wdata : sel1 ? m1_wdata : '0;
  assign s_wstrb = sel0 ? m0_wstrb : sel1 ? m1_wstrb : '0;
  assign m0_ready = sel0 & own_ready;
  assign m1_ready = sel1 & own_ready;
  assign m0_rdata = sel0 ? own_rdata : '0;
  assign m1_rdata = sel1 ? own_rdata : '0;
  assign grant = owner_q;
  assign timeout_err = tmo;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign pick = (m1_valid && (!m0_valid || !last_q)) ? OWN_M1 : OWN_M0;
`else
  assign pick = m0_valid ? OWN_M0 : OWN_M1;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    if (state_q == ARB_IDLE) begin
      if (m0_valid || m1_valid) begin
        state_d = ARB_BUSY;
        owner_d = pick;
        last_d = pick == OWN_M1;
      end
    end else if (!own_valid || own_ready) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter (TIMEOUT = 4)
// with a transaction-level grant-order model for the contention test.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, resetn;
  logic m0_valid, m0_instr, m0_ready, m1_valid, m1_instr, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic s_valid, s_instr, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0] grant;
  logic [138:0] all_out;
  int checks = 0, errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  assign all_out = {s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata,
                    m1_ready, m1_rdata, grant, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb} = '0;
    {m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb} = '0;
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  task automatic test_reset();
    quiet();
    resetn = 1'b0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    #3;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    tick();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", all_out); end
    quiet();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0010;
    #1;
    checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0) begin
      errors++; $display("FAIL rd_arb_cycle: grant=%b s_valid=%b want 00/0", grant, s_valid);
    end
    tick();
    checks++;
    if ({grant, s_valid, s_addr, m0_ready, m1_ready} !== {2'b01, 1'b1, 32'h10, 2'b00}) begin
      errors++; $display("FAIL rd_busy1: grant=%b s_valid=%b s_addr=%h rdy=%b%b", grant, s_valid, s_addr, m0_ready, m1_ready);
    end
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err} !== {1'b1, 32'h1234_5678, 33'h0, 1'b0}) begin
      errors++; $display("FAIL rd_complete: m0 %b/%h m1 %b/%h tmo=%b want 1/12345678 0/0 0", m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err);
    end
    tick();
    quiet();
    #1;
    checks++;
    if ({grant, m0_ready, m0_rdata, s_valid} !== '0) begin
      errors++; $display("FAIL rd_after: grant=%b m0_ready=%b m0_rdata=%h s_valid=%b want 0", grant, m0_ready, m0_rdata, s_valid);
    end
  endtask

  task automatic test_write_m1();
    m1_valid = 1'b1;
    m1_addr = 32'h100;
    m1_wdata = 32'hA5A5_A5A5;
    m1_wstrb = 4'b0011;
    tick();
    for (int c = 1; c <= 3; c++) begin
      s_ready = (c == 3);
      #1;
      checks++;
      if ({grant, s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready} !== {2'b10, 2'b10, 32'h100, 32'hA5A5_A5A5, 4'b0011, 1'b0}) begin
        errors++; $display("FAIL wr_fields c%0d: grant=%b v=%b a=%h d=%h s=%b m0r=%b", c, grant, s_valid, s_addr, s_wdata, s_wstrb, m0_ready);
      end
      checks++;
      if (m1_ready !== (c == 3)) begin errors++; $display("FAIL wr_ready c%0d: got %b want %b", c, m1_ready, c == 3); end
      tick();
    end
    quiet();
  endtask

  task automatic test_timeout();
    m0_valid = 1'b1;
    m0_addr = $urandom;
    s_rdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (c < 4 && {m0_ready, timeout_err, s_valid} !== 3'b001) begin
        errors++; $display("FAIL tmo_wait c%0d: rdy=%b err=%b v=%b want 0/0/1", c, m0_ready, timeout_err, s_valid);
      end else if (c == 4 && {m0_ready, m0_rdata, timeout_err, s_valid} !== {1'b1, 32'h0, 2'b10}) begin
        errors++; $display("FAIL tmo_fire: rdy=%b rdata=%h err=%b v=%b want 1/0/1/0", m0_ready, m0_rdata, timeout_err, s_valid);
      end
      tick();
    end
    m0_addr = 32'h44;
    s_rdata = '0;
    #1;
    checks++;
    if ({grant, timeout_err} !== 3'b000) begin errors++; $display("FAIL tmo_idle: grant=%b err=%b want 00/0", grant, timeout_err); end
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({grant, s_addr, m0_ready, m0_rdata, timeout_err} !== {2'b01, 32'h44, 1'b1, 32'h0BAD_F00D, 1'b0}) begin
      errors++; $display("FAIL tmo_next: grant=%b a=%h rdy=%b rdata=%h err=%b", grant, s_addr, m0_ready, m0_rdata, timeout_err);
    end
    tick();
    quiet();
  endtask

  task automatic test_ready_at_limit();
    logic [31:0] v;
    v = $urandom;
    m0_valid = 1'b1;
    m0_addr = 32'h80;
    tick();
    for (int c = 1; c <= 4; c++) begin
      s_ready = (c == 4);
      s_rdata = (c == 4) ? v : 32'h0;
      #1;
      checks++;
      if ({m0_ready, m0_rdata, timeout_err, s_valid} !== {c == 4, (c == 4) ? v : 32'h0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL limit c%0d: rdy=%b rdata=%h err=%b v=%b want rdata %h", c, m0_ready, m0_rdata, timeout_err, s_valid, v);
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_contention();
    logic [31:0] a[2][4], d[2][4];
    logic [3:0] st[2][4];
    logic ins[2][4];
    int idx[2], pend[2];
    int exp_order[$];
    int w, lat, busy, cyc, k;
    bit idle_exp, last_m1;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) begin
        a[m][i] = $urandom; d[m][i] = $urandom;
        st[m][i] = 4'($urandom); ins[m][i] = 1'($urandom);
      end
    pend = '{4, 4};
    last_m1 = 1'b1;
    while (pend[0] + pend[1] > 0) begin
      if (pend[0] > 0 && pend[1] > 0) w = (RR && !last_m1) ? 1 : 0;
      else w = (pend[0] > 0) ? 0 : 1;
      exp_order.push_back(w);
      pend[w]--;
      last_m1 = (w == 1);
    end
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    idx = '{0, 0};
    idle_exp = 1'b1;
    busy = 0; cyc = 0; k = 0; w = 0; lat = 1;
    while (k < exp_order.size() && cyc < 200) begin
      m0_valid = idx[0] < 4;
      if (idx[0] < 4) {m0_instr, m0_addr, m0_wdata, m0_wstrb} = {ins[0][idx[0]], a[0][idx[0]], d[0][idx[0]], st[0][idx[0]]};
      m1_valid = idx[1] < 4;
      if (idx[1] < 4) {m1_instr, m1_addr, m1_wdata, m1_wstrb} = {ins[1][idx[1]], a[1][idx[1]], d[1][idx[1]], st[1][idx[1]]};
      s_ready = 1'b0;
      s_rdata = '0;
      #1;
      if (idle_exp) begin
        checks++;
        if (grant !== 2'b00 || s_valid !== 1'b0) begin errors++; $display("FAIL cont_idle k%0d: grant=%b v=%b want 00/0", k, grant, s_valid); end
        idle_exp = 1'b0;
        busy = 0;
        w = exp_order[k];
        lat = $urandom_range(1, 3);
      end else begin
        busy++;
        checks++;
        if (grant !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant k%0d: got %b want m%0d", k, grant, w); end
        checks++;
        if ({s_valid, s_instr, s_addr, s_wdata, s_wstrb} !== {1'b1, ins[w][idx[w]], a[w][idx[w]], d[w][idx[w]], st[w][idx[w]]}) begin
          errors++; $display("FAIL cont_fields k%0d: v=%b a=%h d=%h s=%b want m%0d a=%h", k, s_valid, s_addr, s_wdata, s_wstrb, w, a[w][idx[w]]);
        end
        if (busy == lat) begin
          s_ready = 1'b1;
          s_rdata = $urandom;
          #1;
          checks++;
          if ({m1_ready, m0_ready} !== (w ? 2'b10 : 2'b01) || (w ? m1_rdata : m0_rdata) !== s_rdata ||
              (w ? m0_rdata : m1_rdata) !== 32'h0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL cont_done k%0d: rdy=%b%b rd0=%h rd1=%h want m%0d %h", k, m1_ready, m0_ready, m0_rdata, m1_rdata, w, s_rdata);
          end
          idx[w]++;
          k++;
          idle_exp = 1'b1;
        end else begin
          checks++;
          if ({m1_ready, m0_ready} !== 2'b00) begin errors++; $display("FAIL cont_early k%0d: rdy=%b%b want 00", k, m1_ready, m0_ready); end
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (k != exp_order.size()) begin errors++; $display("FAIL cont_budget: %0d of %0d transactions done", k, exp_order.size()); end
    quiet();
    tick();
  endtask

  task automatic test_reset_mid();
    m0_valid = 1'b1;
    m0_addr = 32'h200;
    tick();
    #1;
    checks++;
    if ({grant, s_valid} !== 3'b011) begin errors++; $display("FAIL rst_pre: grant=%b v=%b want 01/1", grant, s_valid); end
    m1_valid = 1'b1;
    s_rdata = 32'h5555_AAAA;
    resetn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_async: got %h want 0", all_out); end
    tick();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_held: got %h want 0", all_out); end
    resetn = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL rst_idle: grant=%b want 00", grant); end
    tick();
    s_ready = 1'b1;
    #1;
    checks++;
    if ({grant, s_addr, m0_ready, m1_ready, m0_rdata} !== {2'b01, 32'h200, 2'b10, 32'h5555_AAAA}) begin
      errors++; $display("FAIL rst_tie: grant=%b a=%h rdy=%b%b rd=%h want m0", grant, s_addr, m0_ready, m1_ready, m0_rdata);
    end
    tick();
    quiet();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_m1();
    test_timeout();
    test_ready_at_limit();
    test_contention();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter for the native picorv32 memory bus (valid/ready/addr/wdata/wstrb/rdata). It sits between the CPU and the on-chip memory/address-decoder path, and lets a second requester share the single memory port without a second port on the RAM. That second requester is a boot loader or a DMA/trace unit. It also guards the CPU against a hung slave with a timeout counter.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `wstrb` width is `DATA_W/8`
- `TIMEOUT`, 255, maximum busy cycles before forced completion; 0 disables the timeout

Ports:
- `clk`  in  1  single system clock
- `resetn`  in  1  asynchronous, active-low reset
- `m0_valid`, `m0_instr`  in  1 each  master 0 (CPU) request and instruction-fetch flag
- `m0_addr`  in  `ADDR_W`
- `m0_wdata`  in  `DATA_W`
- `m0_wstrb`  in  `DATA_W/8`  all zero means read
- `m0_ready`  out  1  completion pulse to master 0
- `m0_rdata`  out  `DATA_W`
- `m1_*`  same set as `m0_*` for master 1
- `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`  out  to the slave
- `s_ready`  in  1
- `s_rdata`  in  `DATA_W`
- `grant`  out  2  one-hot current owner; 00 when idle
- `timeout_err`  out  1  one-cycle pulse when a transaction is force-completed

## Operation
- Masters follow picorv32 rules: assert valid, hold all request fields stable until ready, then drop valid (or start a new request).
- States:
  - IDLE: if any `mX_valid`, select a winner by policy (see Configuration), register it as owner and the `last` flag, clear the counter, go to BUSY. Otherwise stay.
  - BUSY: the `s_*` request fields are a combinational mux of the owner's fields. `s_valid` is the owner's valid.
- Leaving BUSY:
  - `s_valid && s_ready`: `owner_ready` is 1 this cycle and `owner_rdata = s_rdata`; go to IDLE.
  - Counter reaches `TIMEOUT` first (and `TIMEOUT != 0`): force `s_valid = 0`, `owner_ready = 1`, `owner_rdata = 0`, `timeout_err = 1`; go to IDLE.
  - Owner drops valid (protocol violation): `s_valid` follows it low; go to IDLE with no ready.
- The counter increments every BUSY cycle and saturates. Its width is `$clog2(TIMEOUT+1)`, minimum 1.
- `s_ready` is ignored in IDLE.
- The non-owner always sees `ready = 0` and `rdata = 0`. Its request waits with no timeout applied.
- `mX_rdata` is zero whenever `mX_ready` is 0.
- Reset (async, any state including mid-transaction): state IDLE, owner none, `last` = m1, counter 0. All outputs are 0: `s_valid`, `m0_ready`, `m1_ready`, `grant`, `timeout_err`, all data and address buses.
  - An in-flight slave access is abandoned. The slave must tolerate `s_valid` dropping.

## Timing
- Arbitration costs one cycle.
  - A master's valid is first sampled in IDLE at edge N; `s_valid` is high from N+1.
  - With a combinational-ready slave, ready returns in cycle N+1.
- After every completion there is exactly one IDLE cycle before the next grant.
  - Back-to-back throughput is one transaction per 2 cycles plus slave latency.
- Ready pulses last exactly one cycle and occur only in BUSY.
- Timeout fires on the `TIMEOUT`-th BUSY cycle without `s_ready`.
  - If `s_ready` arrives in that same cycle, it is a normal completion and `timeout_err` stays 0.
- Simultaneous valid in IDLE is resolved by policy. A lone requester is always granted.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: on a tie in IDLE, the master not named by `last` wins, so strict alternation occurs under continuous contention.
  - Undefined: fixed priority, m0 (CPU) always wins. The `last` register is still kept but unused.
  - Non-tie behaviour is identical in both modes.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum (`ARB_IDLE`, `ARB_BUSY`)
  - owner encoding constants (`OWN_NONE`, `OWN_M0`, `OWN_M1`)
  - default widths 32/32
- Optional sub-module `mem_arb_timeout`: saturating counter with start/clear inputs and an expired output, parameterised by `TIMEOUT`.
- The remaining mux, FSM and policy logic is flat in `mem_bus_arbiter`.

## Test plan
- Single master, m0 read of addr 0x0000_0010, slave ready after 2 cycles with rdata 0x1234_5678 -> `s_valid` high from cycle 1, `m0_ready` one pulse, `m0_rdata` = 0x1234_5678, `grant` 01 then 00, m1 sees nothing.
- Both assert in the same cycle, continuous, 4 transactions each -> with `MEM_ARB_ROUND_ROBIN_EN` grants m0,m1,m0,m1,…; without it all 4 m0 grants complete before any m1 grant.
- m1 write with addr 0x100, wdata 0xA5A5_A5A5, wstrb 0b0011 -> slave sees exactly those fields stable until `s_ready`; `m0_ready` stays 0.
- `TIMEOUT` = 4, slave never ready -> after 4 BUSY cycles `m0_ready` = 1, `m0_rdata` = 0, `timeout_err` one pulse, `s_valid` 0, next grant proceeds normally.
- `s_ready` on exactly the 4th BUSY cycle with `TIMEOUT` = 4 -> normal completion, rdata passed through, `timeout_err` = 0.
- `resetn` pulsed low mid-BUSY -> all outputs 0 asynchronously, FSM IDLE; after release, first tie is granted to m0.
